// File: rtl/mem_pkg.sv
// Shared types and helpers for the data memory responder: the access-size
// encoding, the responder FSM states, request error classification and
// byte-lane mask generation.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_B   = 2'd0,
    MEM_H   = 2'd1,
    MEM_W   = 2'd2,
    MEM_RSV = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // A request is rejected for a reserved size, a misaligned half or word,
  // or any address at or beyond the end of the array.
  function automatic logic req_is_err(input logic [1:0]  size,
                                      input logic [31:0] addr,
                                      input logic [31:0] mem_bytes);
    logic err;
    err = 1'b0;
    if (size == MEM_RSV) err = 1'b1;
    if ((size == MEM_H) && addr[0]) err = 1'b1;
    if ((size == MEM_W) && (addr[1:0] != 2'b00)) err = 1'b1;
    if (addr >= mem_bytes) err = 1'b1;
    return err;
  endfunction

  // Byte lanes touched by a store of the given size at the given lane offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] lane);
    logic [3:0] mask;
    case (size)
      MEM_B:   mask = 4'b0001 << lane;
      MEM_H:   mask = 4'b0011 << lane;
      MEM_W:   mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte or half-word lane from a little-endian 32-bit
// memory word and zero- or sign-extends it to 32 bits.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  mem_size_t   size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // Right-align the addressed lane, then extend according to size and signedness.
  always_comb begin
    shifted = word >> {lane, 3'b000};
    data    = '0;
    case (size)
      MEM_B:   data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      MEM_H:   data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      MEM_W:   data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding-request data memory with a fixed response latency.
// A request is captured when accepted, waits out the latency, and the memory
// is read or written on the edge that enters RESP. The response then holds
// until the initiator takes it.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int MEM_BYTES = 131072,
  parameter int LATENCY   = 2
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW        = $clog2(MEM_BYTES);
  localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  logic [31:0] mem [0:(MEM_BYTES/4)-1];

  state_t        state;
  logic [3:0]    cnt;
  logic          write_q;
  logic          unsigned_q;
  logic          err_q;
  mem_size_t     size_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   raw_q;
  logic [31:0]   ext_data;

  logic          accept;
  logic          in_err;
  logic          enter_resp;
  logic          c_write;
  logic          c_err;
  logic [1:0]    c_size;
  logic [AW-1:0] c_addr;
  logic [31:0]   c_wdata;
  logic [31:0]   c_wdata_al;
  logic [3:0]    c_be;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign in_err    = req_is_err(req_size, req_addr, MEM_LIMIT);

  // Choose which request the commit edge acts on: with a one-cycle latency
  // the commit coincides with acceptance, so the live inputs are used;
  // otherwise the captured request drives the memory.
  always_comb begin
    enter_resp = 1'b0;
    c_write    = write_q;
    c_err      = err_q;
    c_size     = size_q;
    c_addr     = addr_q;
    c_wdata    = wdata_q;
    if (state == ST_IDLE) begin
      enter_resp = accept && (LATENCY == 1);
      c_write    = req_write;
      c_err      = in_err;
      c_size     = req_size;
      c_addr     = req_addr[AW-1:0];
      c_wdata    = req_wdata;
    end else if (state == ST_WAIT) begin
      enter_resp = (cnt == 4'd1);
    end
    c_wdata_al = c_wdata << {c_addr[1:0], 3'b000};
    c_be       = lane_mask(c_size, c_addr[1:0]);
  end

  // Request sequencing: capture on accept, count down the latency, hold the
  // response until it is taken. Reset drops any request in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= MEM_B;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            write_q    <= req_write;
            unsigned_q <= req_unsigned;
            err_q      <= in_err;
            size_q     <= mem_size_t'(req_size);
            addr_q     <= req_addr[AW-1:0];
            wdata_q    <= req_wdata;
            if (LATENCY == 1) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd1) begin
            state <= ST_RESP;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Single commit point for the array: write the enabled lanes or latch the
  // addressed word. Contents are never cleared, and reset blocks the commit.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && !c_err) begin
      if (c_write) begin
        for (int b = 0; b < 4; b++) begin
          if (c_be[b]) mem[c_addr[AW-1:2]][8*b +: 8] <= c_wdata_al[8*b +: 8];
        end
      end else begin
        raw_q <= mem[c_addr[AW-1:2]];
      end
    end
  end

  load_extend u_load_extend (
    .word        (raw_q),
    .lane        (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .data        (ext_data)
  );

  assign resp_valid = (state == ST_RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q && !write_q) ? ext_data : 32'd0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with LATENCY=2: stores, signed and
// unsigned loads, error cases, response back-pressure and reset mid-request.
module tb_data_mem_responder;

  localparam int MEM_BYTES = 131072;
  localparam int LATENCY   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int passed = 0;
  int total  = 0;

  data_mem_responder #(.MEM_BYTES(MEM_BYTES), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, confirm it is accepted, then confirm resp_valid is
  // low after the acceptance edge and high one edge later (two cycles after
  // the cycle the request was presented in).
  task automatic applyStimulus(input string tag, input logic wr, input logic [1:0] sz,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    req_valid    = 1'b1;
    check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    check({tag, ".lat1"}, {31'd0, resp_valid}, 32'd0);
    tick();
    check({tag, ".lat2"}, {31'd0, resp_valid}, 32'd1);
  endtask

  // Check the held response, take it, and confirm the responder is idle again.
  task automatic checkOutput(input string tag, input logic [31:0] exp_rdata, input logic exp_err);
    check({tag, ".rdata"}, resp_rdata, exp_rdata);
    check({tag, ".err"}, {31'd0, resp_err}, {31'd0, exp_err});
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, ".done"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    rst          = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;
    resp_ready   = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("reset.resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset.resp_rdata", resp_rdata, 32'd0);
    check("reset.resp_err", {31'd0, resp_err}, 32'd0);
    check("reset.req_ready", {31'd0, req_ready}, 32'd1);

    applyStimulus("st_w100", 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
    checkOutput("st_w100", 32'd0, 1'b0);
    applyStimulus("ld_w100", 1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    checkOutput("ld_w100", 32'hDEADBEEF, 1'b0);
    applyStimulus("ld_b103s", 1'b0, 2'd0, 1'b0, 32'h103, 32'd0);
    checkOutput("ld_b103s", 32'hFFFFFFDE, 1'b0);
    applyStimulus("ld_b103u", 1'b0, 2'd0, 1'b1, 32'h103, 32'd0);
    checkOutput("ld_b103u", 32'h000000DE, 1'b0);
    applyStimulus("ld_h102s", 1'b0, 2'd1, 1'b0, 32'h102, 32'd0);
    checkOutput("ld_h102s", 32'hFFFFDEAD, 1'b0);
    applyStimulus("ld_h100u", 1'b0, 2'd1, 1'b1, 32'h100, 32'd0);
    checkOutput("ld_h100u", 32'h0000BEEF, 1'b0);
    applyStimulus("ld_b101s", 1'b0, 2'd0, 1'b0, 32'h101, 32'd0);
    checkOutput("ld_b101s", 32'hFFFFFFBE, 1'b0);

    applyStimulus("st_h101", 1'b1, 2'd1, 1'b0, 32'h101, 32'h0000AAAA);
    checkOutput("st_h101", 32'd0, 1'b1);
    applyStimulus("ld_after_err", 1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    checkOutput("ld_after_err", 32'hDEADBEEF, 1'b0);
    applyStimulus("ld_oob", 1'b0, 2'd2, 1'b0, MEM_BYTES, 32'd0);
    checkOutput("ld_oob", 32'd0, 1'b1);
    applyStimulus("rsv_size", 1'b1, 2'd3, 1'b0, 32'h100, 32'h11111111);
    checkOutput("rsv_size", 32'd0, 1'b1);
    applyStimulus("ld_w102", 1'b0, 2'd2, 1'b0, 32'h102, 32'd0);
    checkOutput("ld_w102", 32'd0, 1'b1);
    applyStimulus("ld_after_rsv", 1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    checkOutput("ld_after_rsv", 32'hDEADBEEF, 1'b0);

    // Back-pressure: response held for 5 cycles while a competing store is offered.
    applyStimulus("bp", 1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'd2;
    req_addr  = 32'h100;
    req_wdata = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      check("bp.valid", {31'd0, resp_valid}, 32'd1);
      check("bp.rdata", resp_rdata, 32'hDEADBEEF);
      check("bp.ready", {31'd0, req_ready}, 32'd0);
      tick();
    end
    req_valid = 1'b0;
    checkOutput("bp", 32'hDEADBEEF, 1'b0);
    applyStimulus("bp_nowrite", 1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    checkOutput("bp_nowrite", 32'hDEADBEEF, 1'b0);

    // Partial stores touch only their lanes.
    applyStimulus("st_b101", 1'b1, 2'd0, 1'b0, 32'h101, 32'hFFFFFF77);
    checkOutput("st_b101", 32'd0, 1'b0);
    applyStimulus("st_h102", 1'b1, 2'd1, 1'b0, 32'h102, 32'hFFFF1234);
    checkOutput("st_h102", 32'd0, 1'b0);
    applyStimulus("ld_w100b", 1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    checkOutput("ld_w100b", 32'h123477EF, 1'b0);
    applyStimulus("ld_b102s", 1'b0, 2'd0, 1'b0, 32'h102, 32'd0);
    checkOutput("ld_b102s", 32'h00000034, 1'b0);

    // Reset while a store waits must cancel the store.
    applyStimulus("st_w200", 1'b1, 2'd2, 1'b0, 32'h200, 32'hCAFEF00D);
    checkOutput("st_w200", 32'd0, 1'b0);
    req_write = 1'b1;
    req_size  = 2'd2;
    req_addr  = 32'h200;
    req_wdata = 32'h12345678;
    req_valid = 1'b1;
    check("rstwait.ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("rstwait.valid_in_rst", {31'd0, resp_valid}, 32'd0);
    check("rstwait.rdata_in_rst", resp_rdata, 32'd0);
    rst = 1'b1;
    tick();
    check("rstwait.valid_after", {31'd0, resp_valid}, 32'd0);
    check("rstwait.ready_after", {31'd0, req_ready}, 32'd1);
    applyStimulus("ld_w200", 1'b0, 2'd2, 1'b0, 32'h200, 32'd0);
    checkOutput("ld_w200", 32'hCAFEF00D, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter MEM_BYTES, 131072, byte capacity of the data array (power of two).
REQ-002 Parameter LATENCY, 2, cycles from request acceptance to response valid (range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-009 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned (low bytes used for byte/half).
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  initiator accepts the response this cycle.
REQ-014 resp_rdata  output  32  load result, extended per size/unsigned; 0 for stores and errors.
REQ-015 resp_err  output  1  request was misaligned, out of range, or reserved size.

Function
REQ-016 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 Request accepted on the edge where req_valid && req_ready; all request fields captured into internal registers on that edge.
REQ-018 On acceptance: LATENCY=1 -> go to RESP directly; else go to WAIT with counter loaded to LATENCY-1.
REQ-019 WAIT decrements the counter each cycle; on the edge counter reaches 1 -> RESP.
REQ-020 resp_valid SHALL rise exactly LATENCY cycles after the acceptance edge and stay high, with rdata/err stable, until resp_valid && resp_ready.
REQ-021 Memory read or write SHALL occur on the edge entering RESP (single commit point).
REQ-022 On the handshake edge RESP -> IDLE; new request cannot be accepted in the same cycle (one outstanding request, no bypass).
REQ-023 Byte order little-endian; store writes only the 1, 2 or 4 addressed byte lanes.
REQ-024 Error when: size=3; size=1 and addr[0]=1; size=2 and addr[1:0]!=0; addr >= MEM_BYTES.
REQ-025 Errored request: no memory write, resp_rdata=0, resp_err=1, same latency as normal request.
REQ-026 Load extension: byte uses bit 7, half uses bit 15 as sign when req_unsigned=0.
REQ-027 resp_rdata=0 and resp_err=0 whenever resp_valid=0.
REQ-028 Request inputs ignored when req_ready=0; resp_ready ignored when resp_valid=0.

Reset
REQ-029 rst=0 at an edge: state IDLE, counter 0, req_ready 1 after release, resp_valid 0, resp_rdata 0, resp_err 0.
REQ-030 Reset during WAIT SHALL drop the request with no memory write; reset during RESP drops the response.
REQ-031 Memory array contents SHALL NOT be cleared by reset.

Structure
REQ-032 Shared package mem_pkg holds size encoding enum (MEM_B, MEM_H, MEM_W) and FSM state enum.
REQ-033 One combinational sub-module load_extend: lane select by addr[1:0], size, unsigned -> 32-bit result.

Verification
REQ-034 Store word 0xDEADBEEF @0x100, load word @0x100, LATENCY=2 -> resp_valid 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-035 Load byte @0x103 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; load half @0x102 signed -> 0xFFFFDEAD.
REQ-036 Store half @0x101 -> resp_err 1, rdata 0; subsequent load word @0x100 still 0xDEADBEEF.
REQ-037 Load @MEM_BYTES and size=3 request -> resp_err 1, no state corruption.
REQ-038 Hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable, req_ready 0 throughout; accept on 6th.
REQ-039 Store word 0x12345678 @0x200 then assert rst in WAIT -> after release, load @0x200 returns prior contents, resp_valid 0 immediately after reset.
